shared_reg_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit D-type storage register among N_REQ requesters. Each requester presents a write request with data. The arbiter grants one requester at a time, loads that requester's data into the shared register, and reports the owner. A programmable hold window keeps the stored value stable for a minimum number of cycles before the next write. It sits between independent producer blocks and the flip-flop storage, so it is the only writer of that register.

---
 rtl/shared_reg_arbiter_pkg.sv | 16 +
 rtl/shared_reg_arbiter_if.sv | 35 +++
 rtl/shared_reg_arbiter_rr_pick.sv | 39 +++
 rtl/shared_reg_arbiter.sv | 88 ++++++++
 tb/tb_shared_reg_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter.
//   state_t     : FSM state encoding (IDLE / GRANT / HOLD)
//   clog2_min1  : ceil(log2(n)) but never less than 1, for index/counter widths
package shared_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
//   req   : per-requester write request (level)
//   wdata : data lanes, lane i at wdata[i*WIDTH +: WIDTH]
//   gnt   : one-hot, one-cycle grant pulse
//   q     : shared register contents
//   owner : index of the last granted requester
//   valid : q written at least once since reset
//   busy  : arbiter not idle
// Modports: master = requester side, slave = arbiter side.
interface shared_reg_arbiter_if
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int PW = clog2_min1(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic [PW-1:0]          owner;
    logic                   valid;
    logic                   busy;

    modport master (
        output req, wdata,
        input  gnt, q, owner, valid, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, q, owner, valid, busy
    );
endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index searched first; search wraps from N_REQ-1 back to 0
//   sel     : first requesting index at or after ptr
//   onehot  : one-hot of sel, all zero when nothing is requested
//   any_req : at least one request present
module rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    sel,
    output logic [N_REQ-1:0] onehot,
    output logic             any_req
);
    int   idx;
    logic found;

    always_comb begin
        idx    = 0;
        found  = 1'b0;
        sel    = '0;
        onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Explicit wrap: N_REQ need not be a power of two.
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
        if (found) onehot[sel] = 1'b1;
        any_req = found;
    end
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning a single shared WIDTH-bit register.
// A requester granted in IDLE has its lane loaded into q on the same edge;
// the register is then held for at least HOLD cycles before the next grant.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : requester bus (slave modport)
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input logic                clk,
    input logic                rst,
    shared_reg_arbiter_if.slave bus
);
    localparam int            PW       = clog2_min1(N_REQ);
    localparam int            CW       = clog2_min1(HOLD + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'((HOLD > 0) ? HOLD - 1 : 0);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    sel;
    logic [N_REQ-1:0] onehot;
    logic             any_req;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .sel     (sel),
        .onehot  (onehot),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            bus.gnt   <= '0;
            bus.q     <= '0;
            bus.owner <= '0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.gnt <= '0;
                    if (any_req) begin
                        state     <= S_GRANT;
                        bus.gnt   <= onehot;
                        bus.q     <= bus.wdata[int'(sel)*WIDTH +: WIDTH];
                        bus.owner <= sel;
                        bus.valid <= 1'b1;
                        bus.busy  <= 1'b1;
                        ptr       <= (sel == LAST_IDX) ? '0 : sel + PW'(1);
                    end
                end
                S_GRANT: begin
                    bus.gnt <= '0;
                    if (HOLD == 0) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state <= S_HOLD;
                        cnt   <= CNT_INIT;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: a HOLD=2 instance driven through
// reset, single request, fairness, wrap/skip and reset-mid-HOLD scenarios with
// a grant scoreboard, plus a HOLD=0 instance checked cycle by cycle.
module tb_shared_reg_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        int         owner;
        int         gap;     // expected cycles since previous grant, -1 = unchecked
    } exp_t;

    typedef struct {
        logic [3:0] gnt;
        logic       busy;
    } cyc_t;

    logic clk = 1'b0;
    logic rst;
    logic rst0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    exp_t sb[$];
    cyc_t sb0[$];

    shared_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) b ();
    shared_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) b0 ();

    shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD(0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (b0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Grant monitor for the HOLD=2 instance.
    exp_t       e;
    int         last_cyc = 0;
    logic [3:0] prev_gnt = '0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (prev_gnt != 4'b0000) chk("gnt_one_cycle", 32'(b.gnt), 32'h0);
            if (b.gnt != 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_gnt", 32'(b.gnt), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("gnt",   32'(b.gnt),   32'(e.gnt));
                    chk("q",     32'(b.q),     32'(e.q));
                    chk("owner", 32'(b.owner), 32'(e.owner));
                    chk("valid", 32'(b.valid), 32'h1);
                    chk("busy",  32'(b.busy),  32'h1);
                    if (e.gap >= 0) chk("grant_gap", 32'(cyc - last_cyc), 32'(e.gap));
                end
                last_cyc = cyc;
            end
        end
        prev_gnt = b.gnt;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        rst      = 1'b1;
        rst0     = 1'b1;
        b.req    = 4'b1111;
        b.wdata  = {8'h44, 8'h33, 8'h22, 8'h11};
        b0.req   = '0;
        b0.wdata = '0;

        // Reset holds everything at zero despite pending requests.
        repeat (2) begin
            step();
            chk("rst_gnt",   32'(b.gnt),   32'h0);
            chk("rst_q",     32'(b.q),     32'h0);
            chk("rst_owner", 32'(b.owner), 32'h0);
            chk("rst_valid", 32'(b.valid), 32'h0);
            chk("rst_busy",  32'(b.busy),  32'h0);
            chk("rst0_gnt",  32'(b0.gnt),  32'h0);
        end
        rst   = 1'b0;
        b.req = '0;

        // Single request from requester 2.
        step();
        b.wdata[23:16] = 8'hA5;
        b.req          = 4'b0100;
        sb.push_back('{4'b0100, 8'hA5, 2, -1});
        step();
        b.req = '0;
        nb    = int'(b.busy);
        repeat (5) begin
            step();
            nb += int'(b.busy);
            chk("single_q_stable", 32'(b.q), 32'hA5);
        end
        chk("single_busy_len", 32'(nb), 32'd3);
        chk("single_valid",    32'(b.valid), 32'h1);

        // Fresh reset, then fairness under continuous requests.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        b.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        b.req   = 4'b1111;
        sb.push_back('{4'b0001, 8'h11, 0, -1});
        sb.push_back('{4'b0010, 8'h22, 1, 4});
        sb.push_back('{4'b0100, 8'h33, 2, 4});
        sb.push_back('{4'b1000, 8'h44, 3, 4});
        sb.push_back('{4'b0001, 8'h11, 0, 4});
        repeat (17) step();
        b.req = '0;
        repeat (5) step();

        // Wrap-around and skip: grant 2 (ptr -> 3), then 3 and 0.
        b.wdata[23:16] = 8'h5A;
        b.req          = 4'b0100;
        sb.push_back('{4'b0100, 8'h5A, 2, -1});
        step();
        b.req = '0;
        repeat (3) step();
        b.wdata[31:24] = 8'h9C;
        b.wdata[7:0]   = 8'h3E;
        b.req          = 4'b1001;
        sb.push_back('{4'b1000, 8'h9C, 3, -1});
        sb.push_back('{4'b0001, 8'h3E, 0, 4});
        step();
        b.req = 4'b0001;
        repeat (4) step();
        b.req = '0;
        repeat (3) step();

        // Reset in the second HOLD cycle.
        b.wdata[7:0] = 8'h77;
        b.req        = 4'b0001;
        sb.push_back('{4'b0001, 8'h77, 0, -1});
        step();
        b.req = '0;
        step();
        step();
        rst            = 1'b1;
        b.req          = 4'b1010;
        b.wdata[15:8]  = 8'hC3;
        b.wdata[31:24] = 8'hD4;
        step();
        chk("midhold_gnt",   32'(b.gnt),   32'h0);
        chk("midhold_q",     32'(b.q),     32'h0);
        chk("midhold_owner", 32'(b.owner), 32'h0);
        chk("midhold_valid", 32'(b.valid), 32'h0);
        chk("midhold_busy",  32'(b.busy),  32'h0);
        rst = 1'b0;
        sb.push_back('{4'b0010, 8'hC3, 1, -1});
        step();
        b.req = '0;
        repeat (4) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        // HOLD=0 instance: grant every other cycle, busy half the time.
        rst0 = 1'b0;
        step();
        b0.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        b0.req   = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) sb0.push_back('{4'(1 << (i / 2)), 1'b1});
            else            sb0.push_back('{4'b0000, 1'b0});
        end
        for (int i = 0; i < 8; i++) begin
            cyc_t c;
            step();
            c = sb0.pop_front();
            chk("h0_gnt",  32'(b0.gnt),  32'(c.gnt));
            chk("h0_busy", 32'(b0.busy), 32'(c.busy));
            if (i % 2 == 0) chk("h0_q", 32'(b0.q), 32'(8'h11 * (i / 2 + 1)));
        end
        b0.req = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
